// File: rtl/instr_packer.sv
// Packs decoded instruction fields into a 103-bit packet and buffers them in a
// DEPTH-entry FIFO with one-cycle latency, flush, and a sticky error vector.
module instr_packer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_class,
  input  logic [31:0]                in_pred,
  input  logic [7:0]                 in_flags,
  input  logic [31:0]                in_imm,
  input  logic [7:0]                 in_opcode,
  input  logic [4:0]                 in_rs2,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_warp_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [102:0]               out_pkt,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                err,
  input  logic                       err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] ERR_FMT  = 32'h0000_0004;
  localparam logic [31:0] ERR_OVFL = 32'h0000_0200;

  logic [102:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      err_q, err_d;

  logic [102:0] pkt_d;
  logic         full, onehot, accept, write_req, do_write, pop;
  logic [31:0]  err_new;

  assign pkt_d = {in_warp_id, in_rd, in_rs1, in_rs2, in_opcode,
                  in_imm, in_flags, in_pred, in_class};

  assign onehot    = (in_class == 3'b001) || (in_class == 3'b010) || (in_class == 3'b100);
  assign full      = (count_q == DEPTH_C);
  assign in_ready  = !full && !flush;
  assign accept    = in_valid && in_ready;
  assign write_req = accept && onehot;
  // Overflow guard cannot fire while in_ready gates accept on the registered count.
  assign do_write  = write_req && !full;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  assign out_pkt = mem_q[head_q];
  assign count   = count_q;
  assign err     = err_q;

  always_comb begin
    err_new = '0;
    if (accept && !onehot) err_new = err_new | ERR_FMT;
    if (write_req && full) err_new = err_new | ERR_OVFL;

    err_d   = (err_clr ? 32'h0 : err_q) | err_new;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_write) tail_d = tail_q + PTR_W'(1);
      if (pop)      head_d = head_q + PTR_W'(1);
      case ({do_write, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---- control state ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // ---- storage (no reset) ----
  always_ff @(posedge clk) begin
    if (do_write) mem_q[tail_q] <= pkt_d;
  end

endmodule

// File: doc/instr_packer.md
INSTR_PACKER -- requirements
Module: instr_packer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: producer offers fields this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts fields this cycle.
REQ-006 The block SHALL have port in_class, input, 3 bits: {alu, lsu, special} unit-class flags.
REQ-007 The block SHALL have ports in_pred (32), in_flags (8), in_imm (32), in_opcode (8), in_rs2 (5), in_rs1 (5), in_rd (5) and in_warp_id (5), all inputs, carrying the decoded fields.
REQ-008 The block SHALL have port out_valid, output, 1 bit: head packet valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer takes head packet.
REQ-010 The block SHALL have port out_pkt, output, 103 bits: packed instruction at the FIFO head.
REQ-011 The block SHALL have port flush, input, 1 bit: discard all buffered packets.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of occupied entries.
REQ-013 The block SHALL have port err, output, 32 bits: sticky error vector in the SP error-code bit positions.
REQ-014 The block SHALL have port err_clr, input, 1 bit: clears err.

Function
REQ-015 Packing SHALL use this layout: [0] special=in_class[0]; [1] lsu=in_class[1]; [2] alu=in_class[2]; [34:3] pred; [42:35] flags; [74:43] imm; [82:75] opcode; [87:83] rs2; [92:88] rs1; [97:93] rd; [102:98] warp_id.
REQ-016 Packing SHALL be lossless: each packed field SHALL equal its input bit-for-bit, with no sign extension or truncation.
REQ-017 in_ready SHALL equal (count != DEPTH) && !flush.
REQ-018 An accept SHALL occur when in_valid && in_ready.
REQ-019 On an accept with in_class one-hot, the packet SHALL be written at the tail and the tail pointer SHALL advance modulo DEPTH.
REQ-020 On an accept with in_class not one-hot (000, or two or more bits set), the packet SHALL be dropped: no write, and err bit 2 (0x00000004, decoder wrong instruction format) SHALL be set.
REQ-021 out_valid SHALL equal (count != 0).
REQ-022 out_pkt SHALL show the head entry combinationally from storage.
REQ-023 A pop SHALL occur when out_valid && out_ready; the head pointer SHALL then advance modulo DEPTH.
REQ-024 Latency SHALL be one cycle: a packet accepted in cycle N is visible on out_pkt with out_valid in cycle N+1; there is no same-cycle bypass.
REQ-025 On a simultaneous accept (one-hot) and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 When full, a pop frees the slot but in_ready SHALL stay 0 in that cycle, because in_ready depends only on registered count.
REQ-027 A pop while empty is impossible, since out_valid=0.
REQ-028 If in_valid is held while full, the block SHALL stall without error and SHALL keep the offered data unconsumed.
REQ-029 If an internal write is attempted with count==DEPTH (defensive check), err bit 9 (0x00000200, issue FIFO overflow) SHALL be set and the write SHALL be suppressed.
REQ-030 flush SHALL take priority over accept and pop: next cycle count=0 and pointers=0; entry contents are don't-care.
REQ-031 err bits SHALL be sticky.
REQ-032 err_clr SHALL clear err next cycle; if a new error occurs in the same cycle as err_clr, the new error SHALL win (its bit is set).
REQ-033 err bits other than 2 and 9 SHALL always read 0.

Reset
REQ-034 While rst_n=0 at a clock edge, next state SHALL be: count=0, head=tail=0, err=0.
REQ-035 Consequently, outputs during and after reset SHALL be out_valid=0, in_ready=1 (once flush=0), out_pkt don't-care.
REQ-036 Reset SHALL override flush, err_clr and all handshakes; a packet mid-handshake at reset SHALL be lost.
REQ-037 Storage SHALL need no reset.

Verification
REQ-038 Bench scenario, pack: in_class=100, warp 5, rd 3, rs1 1, rs2 2, opcode 0x13, imm 0xFFFFFFFF, flags 0xA5, pred 0x0000FFFF, one accept -> next cycle out_valid=1, out_pkt fields read back exactly, out_pkt[2:0]=100.
REQ-039 Bench scenario, fill/stall: out_ready=0, DEPTH=4, push 5 distinct packets -> count=4, in_ready=0, 5th held; then out_ready=1 -> packets pop in order 1..5, err=0.
REQ-040 Bench scenario, bad class: in_class=011 accepted -> count unchanged, err=0x00000004; err_clr pulse -> err=0 next cycle.
REQ-041 Bench scenario, simultaneous: count=2, push+pop same cycle -> count stays 2, order preserved.
REQ-042 Bench scenario, flush: count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, input not taken.
REQ-043 Bench scenario, reset mid-stream: count=3, err=0x4, rst_n=0 for one edge -> count=0, err=0, in_ready=1.
